mem_block_copy: RTL and testbench
=================================

Name: mem_block_copy

Overview:
Memory-side initiator for the 16x1k data memory (amemory16x1k). It drives the memory's DataIn, Address and Write inputs and consumes its DataOut. On a Start pulse it copies Count consecutive 16-bit words from SrcAddr to DstAddr, using the memory's single port with registered-address reads. It sits between the control unit or boot logic and the data memory, in front of the datapath's memory port mux.

Parameters:
READ_LAT, 1, memory read latency in cycles from the address edge to valid DataOut (minimum 1).
ADDR_W, 10, memory address width.
DATA_W, 16, memory word width.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  one-cycle request; sampled only in IDLE.
SrcAddr  input  ADDR_W  first source word address; latched on accepted Start.
DstAddr  input  ADDR_W  first destination word address; latched on accepted Start.
Count  input  ADDR_W+1  number of words to copy; latched on accepted Start.
Busy  output  1  high in READ, WAIT and WRITE.
Done  output  1  one-cycle pulse when the copy completes.
MemAddress  output  ADDR_W  to memory Address.
MemDataOut  output  DATA_W  to memory DataIn.
MemWrite  output  1  to memory Write.
MemDataIn  input  DATA_W  from memory DataOut.

Behaviour:
- Reset (synchronous, any state): state = IDLE. Busy, Done, MemWrite = 0. MemAddress, MemDataOut, counters and hold register = 0. A reset mid-copy abandons the copy with no further writes. Any write already performed stays in memory.
- States and transitions:
  - IDLE: Start=1 latches src, dst and remaining = min(Count, 1024).
    - remaining=0 -> DONE.
    - Otherwise -> READ.
  - READ (1 cycle): MemAddress = src, MemWrite = 0 -> WAIT.
  - WAIT (READ_LAT cycles, internal latency counter): MemAddress holds src. On the last WAIT cycle, MemDataIn is captured into the hold register -> WRITE.
  - WRITE (1 cycle): MemAddress = dst, MemDataOut = hold, MemWrite = 1. Then src+1, dst+1, remaining-1.
    - remaining was 1 -> DONE.
    - Otherwise -> READ.
  - DONE (1 cycle): Done = 1, Busy = 0 -> IDLE.
- Throughput: 2 + READ_LAT cycles per word; 3 with the default. First memory access occurs the cycle after Start.
- Address arithmetic is modulo 2^ADDR_W: 1023 + 1 wraps to 0 for both src and dst, with no error.
- Copy order is strictly ascending. Overlapping regions with dst > src propagate already-copied data; this is defined, not guarded.
- Start while not in IDLE is ignored, with no queuing. Start in the DONE cycle is also ignored.
- MemWrite is high only in WRITE and is never high for two consecutive cycles.
- Outputs are registered or decoded from the registered state only. There are no combinational paths from inputs to outputs.

Optional Feature:
Macro MEMCOPY_CHECKSUM_EN.
- Defined: adds output Checksum (DATA_W bits) with the following behaviour.
  - Cleared to 0 on accepted Start and on Reset.
  - Adds each hold word, modulo 2^16, in every WRITE cycle.
  - Stable from the DONE cycle until the next accepted Start.
- Undefined: no Checksum port and no adder logic; all other behaviour is identical.

Decomposition:
- Shared package / header: state encodings (IDLE, READ, WAIT, WRITE, DONE as 3-bit localparams), ADDR_W/DATA_W defaults, the 1024-word max-count constant.
- One natural sub-module: mem_copy_addr_gen. It holds the src/dst/remaining registers with load, increment/wrap and last-word flag. The FSM stays in the top.

Test Plan:
- Preload mem[0x200..0x203] = 0xA001..0xA004. Start with Src=0x200, Dst=0x300, Count=4 -> 4 write cycles, 12 Busy cycles, one Done pulse; mem[0x300..0x303] = 0xA001..0xA004; Checksum = 0x800A if enabled.
- Start with Count=0 -> Done pulses the cycle after Start; Busy and MemWrite never high; memory unchanged.
- Src=0x3FE, Dst=0x000, Count=4, mem[0x3FE,0x3FF,0x000,0x001] = 1,2,3,4 -> source wraps after 0x3FF; final mem[0x000..0x003] = 1,2,1,2, exercising the ascending-overlap rule.
- Assert Reset in the second WAIT cycle of a Count=8 copy -> next cycle IDLE with all outputs 0; only one destination word written; a new Start runs normally.
- Pulse Start again while Busy with different Src/Dst -> ignored; the original copy completes unchanged with a single Done.
- Count=11'h7FF -> clamped to 1024 words; exactly 1024 MemWrite pulses, then Done.

Source files
------------

// File: rtl/mem_block_copy_pkg.sv
// Shared constants for the memory block-copy engine: FSM state codes,
// default widths and the largest copy length.
package mem_block_copy_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int MAX_WORDS  = 1 << ADDR_W_DEF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Source/destination pointers and words-remaining counter for the copy engine.
// Pointers wrap modulo 2^ADDR_W; the requested length is clamped to MAX_CNT.
module mem_copy_addr_gen
    import mem_block_copy_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MAX_CNT = MAX_WORDS
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W:0]   i_count,
    output logic [ADDR_W-1:0] o_src,
    output logic [ADDR_W-1:0] o_dst,
    output logic              o_last,
    output logic              o_zero
);

    localparam logic [ADDR_W:0] MAX_C = (ADDR_W+1)'(MAX_CNT);

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W:0]   w_clamped;

    assign w_clamped = (i_count > MAX_C) ? MAX_C : i_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_src       <= i_src;
            r_dst       <= i_dst;
            r_remaining <= w_clamped;
        end else if (i_step) begin
            r_src       <= r_src + 1'b1;
            r_dst       <= r_dst + 1'b1;
            r_remaining <= r_remaining - 1'b1;
        end
    end

    assign o_src  = r_src;
    assign o_dst  = r_dst;
    assign o_last = (r_remaining == (ADDR_W+1)'(1));
    // Zero-length test looks at the incoming request so IDLE can branch straight to DONE.
    assign o_zero = (i_count == '0);

endmodule

// File: rtl/mem_block_copy.sv
// Block-copy initiator for a single-port, registered-address data memory.
// Optional running checksum output enabled by defining MEMCOPY_CHECKSUM_EN.
//
// state    | meaning
// IDLE     | waiting for Start
// READ     | source address presented to memory
// WAIT     | read latency; last cycle captures MemDataIn into hold
// WRITE    | hold written to destination, pointers advance
// DONE     | one-cycle Done pulse
module mem_block_copy
    import mem_block_copy_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [ADDR_W:0]   Count,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemDataOut,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemDataIn
`ifdef MEMCOPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] Checksum
`endif
);

    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [DATA_W-1:0] r_hold;
    logic [ADDR_W-1:0] w_src;
    logic [ADDR_W-1:0] w_dst;
    logic              w_last;
    logic              w_zero;
    logic              w_load;
    logic              w_step;
    logic              w_lat_tc;

    assign w_load   = (r_state == ST_IDLE) && Start;
    assign w_step   = (r_state == ST_WRITE);
    assign w_lat_tc = (r_lat_cnt == '0);

    mem_copy_addr_gen #(
        .ADDR_W  (ADDR_W),
        .MAX_CNT (1 << ADDR_W)
    ) u_addr_gen (
        .i_clk   (CLK),
        .i_reset (Reset),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_src   (SrcAddr),
        .i_dst   (DstAddr),
        .i_count (Count),
        .o_src   (w_src),
        .o_dst   (w_dst),
        .o_last  (w_last),
        .o_zero  (w_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (Start) w_next = w_zero ? ST_DONE : ST_READ;
            ST_READ:  w_next = ST_WAIT;
            ST_WAIT:  if (w_lat_tc) w_next = ST_WRITE;
            ST_WRITE: w_next = w_last ? ST_DONE : ST_READ;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= '0;
            r_hold    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_READ) begin
                r_lat_cnt <= LAT_W'(READ_LAT - 1);
            end else if ((r_state == ST_WAIT) && !w_lat_tc) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
            if ((r_state == ST_WAIT) && w_lat_tc) begin
                r_hold <= MemDataIn;
            end
        end
    end

`ifdef MEMCOPY_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge CLK) begin
        if (Reset || w_load) begin
            r_checksum <= '0;
        end else if (w_step) begin
            r_checksum <= r_checksum + r_hold;
        end
    end

    assign Checksum = r_checksum;
`endif

    // Address stays on src through WAIT so the memory's registered address is stable.
    always_comb begin
        MemAddress = '0;
        case (r_state)
            ST_READ, ST_WAIT: MemAddress = w_src;
            ST_WRITE:         MemAddress = w_dst;
            default:          MemAddress = '0;
        endcase
    end

    assign MemDataOut = r_hold;
    assign MemWrite   = (r_state == ST_WRITE);
    assign Busy       = (r_state == ST_READ) || (r_state == ST_WAIT) || (r_state == ST_WRITE);
    assign Done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_mem_block_copy.sv
// Scoreboard bench for mem_block_copy with a behavioural 1k x 16 memory.
module tb_mem_block_copy;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [9:0]  SrcAddr = '0;
    logic [9:0]  DstAddr = '0;
    logic [10:0] Count = '0;
    logic        Busy;
    logic        Done;
    logic [9:0]  MemAddress;
    logic [15:0] MemDataOut;
    logic        MemWrite;
    logic [15:0] MemDataIn;
`ifdef MEMCOPY_CHECKSUM_EN
    logic [15:0] Checksum;
`endif

    always #5 CLK = ~CLK;

    mem_block_copy dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Start      (Start),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Count      (Count),
        .Busy       (Busy),
        .Done       (Done),
        .MemAddress (MemAddress),
        .MemDataOut (MemDataOut),
        .MemWrite   (MemWrite),
        .MemDataIn  (MemDataIn)
`ifdef MEMCOPY_CHECKSUM_EN
        ,
        .Checksum   (Checksum)
`endif
    );

    // Registered-address memory, one cycle read latency, plus a bench preload port.
    logic [15:0] tb_mem [1024];
    logic [9:0]  r_mem_addr = '0;
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge CLK) begin
        if (pre_we) tb_mem[pre_addr] <= pre_data;
        else if (MemWrite) tb_mem[MemAddress] <= MemDataOut;
        r_mem_addr <= MemAddress;
    end
    assign MemDataIn = tb_mem[r_mem_addr];

    typedef struct packed {
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [15:0] exp_done_q[$];
    logic [15:0] model_mem [1024];
    int          tests = 0;
    int          fails = 0;
    logic        prev_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every Done pulse must match the next expected entry.
    always @(negedge CLK) begin
        wr_t         e;
        logic [15:0] cs;
        if (MemWrite) begin
            tests++;
            if (exp_wr_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write addr=%h data=%h", MemAddress, MemDataOut);
            end else begin
                e = exp_wr_q.pop_front();
                if (e.a !== MemAddress || e.d !== MemDataOut) begin
                    fails++;
                    $display("FAIL write_data actual=%h:%h required=%h:%h",
                             MemAddress, MemDataOut, e.a, e.d);
                end
            end
            tests++;
            if (prev_wr) begin
                fails++;
                $display("FAIL back_to_back_write actual=1 required=0");
            end
        end
        prev_wr = MemWrite;
        if (Done) begin
            tests++;
            if (exp_done_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                cs = exp_done_q.pop_front();
`ifdef MEMCOPY_CHECKSUM_EN
                if (Checksum !== cs) begin
                    fails++;
                    $display("FAIL checksum actual=%h required=%h", Checksum, cs);
                end
`else
                if (cs === 16'hxxxx) $display("unreachable");
`endif
            end
            tests++;
            if (Busy !== 1'b0) begin
                fails++;
                $display("FAIL busy_in_done actual=%b required=0", Busy);
            end
        end
    end

    task automatic poke(input int a, input logic [15:0] d);
        @(negedge CLK);
        pre_we = 1'b1;
        pre_addr = 10'(a);
        pre_data = d;
        model_mem[a] = d;
    endtask

    task automatic poke_end();
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    // Reference: ascending word-by-word copy with 10-bit wrap, length clamped to 1024.
    task automatic model_copy(input int src, input int dst, input int cnt, output int n);
        logic [15:0] sum;
        logic [15:0] v;
        int s;
        int d;
        n = (cnt > 1024) ? 1024 : cnt;
        sum = 16'h0;
        for (int i = 0; i < n; i++) begin
            s = (src + i) % 1024;
            d = (dst + i) % 1024;
            v = model_mem[s];
            model_mem[d] = v;
            exp_wr_q.push_back('{a: 10'(d), d: v});
            sum = sum + v;
        end
        exp_done_q.push_back(sum);
    endtask

    task automatic mem_compare(input string name);
        int bad = 0;
        for (int i = 0; i < 1024; i++)
            if (tb_mem[i] !== model_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    task automatic run_copy(input int src, input int dst, input int cnt, input bit inject);
        int n;
        int busy_cnt = 0;
        int done_at = 0;
        int post_busy = 0;
        model_copy(src, dst, cnt, n);
        @(negedge CLK);
        SrcAddr = 10'(src);
        DstAddr = 10'(dst);
        Count   = 11'(cnt);
        Start   = 1'b1;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge CLK);
            if (k == 1 || k == 5) Start = 1'b0;
            if (Busy) busy_cnt++;
            if (Done) begin
                done_at = k;
                break;
            end
            if (inject && k == 4) begin
                SrcAddr = 10'($urandom_range(0, 1023));
                DstAddr = 10'($urandom_range(0, 1023));
                Count   = 11'($urandom_range(1, 30));
                Start   = 1'b1;
            end
        end
        Start = 1'b0;
        check("done_latency", done_at, 3 * n + 1);
        check("busy_cycles", busy_cnt, 3 * n);
        if (inject) begin
            SrcAddr = 10'($urandom_range(0, 1023));
            Count   = 11'($urandom_range(1, 30));
            Start   = 1'b1;
            @(negedge CLK);
            Start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK);
                if (Busy) post_busy++;
            end
            check("start_in_done_ignored", post_busy, 0);
        end
        @(negedge CLK);
        check("writes_drained", exp_wr_q.size(), 0);
        if (done_at == 0) begin
            exp_wr_q.delete();
            exp_done_q.delete();
        end
        mem_compare("mem_contents");
    endtask

    initial begin
        int s;
        int d;
        int c;
        // Fill memory with random data while reset is held.
        for (int i = 0; i < 1024; i++) poke(i, 16'($urandom));
        poke_end();
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_memaddr", MemAddress, 0);
        check("rst_memdata", MemDataOut, 0);

        for (int i = 0; i < 4; i++) poke(16'h200 + i, 16'hA001 + 16'(i));
        poke_end();
        run_copy(16'h200, 16'h300, 4, 1'b0);
        for (int i = 0; i < 4; i++) check("directed_dst", tb_mem[16'h300 + i], 16'hA001 + i);
`ifdef MEMCOPY_CHECKSUM_EN
        check("checksum_directed", Checksum, 16'h800A);
`endif

        run_copy(16'h123, 16'h045, 0, 1'b0);

        poke(16'h3FE, 16'd1);
        poke(16'h3FF, 16'd2);
        poke(16'h000, 16'd3);
        poke(16'h001, 16'd4);
        poke_end();
        run_copy(16'h3FE, 16'h000, 4, 1'b0);
        for (int i = 0; i < 4; i++) check("wrap_overlap", tb_mem[i], (i % 2) + 1);

        // Reset during the second word's WAIT: only the first word lands.
        @(negedge CLK);
        SrcAddr = 10'h050;
        DstAddr = 10'h250;
        Count   = 11'd8;
        Start   = 1'b1;
        model_mem[16'h250] = model_mem[16'h050];
        exp_wr_q.push_back('{a: 10'h250, d: model_mem[16'h050]});
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            Start = 1'b0;
        end
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        check("midrst_busy", Busy, 0);
        check("midrst_memwrite", MemWrite, 0);
        check("midrst_memaddr", MemAddress, 0);
        check("midrst_memdata", MemDataOut, 0);
        check("midrst_done", Done, 0);
        check("midrst_writes", exp_wr_q.size(), 0);
        mem_compare("midrst_mem");
        run_copy(16'h050, 16'h250, 8, 1'b0);

        run_copy(16'h080, 16'h1C0, 6, 1'b1);

        for (int t = 0; t < 8; t++) begin
            s = $urandom_range(0, 1023);
            d = $urandom_range(0, 1023);
            c = $urandom_range(0, 24);
            run_copy(s, d, c, 1'($urandom_range(0, 1)));
        end

        run_copy(16'h100, 16'h180, 11'h7FF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
